// File: rtl/cluster_pwr_seq_if.sv
// Control-side bundle of the cluster power sequencer: requests and config in,
// cluster control lines and status out.
interface cluster_pwr_seq_if;
  logic        pwr_up_req_i;
  logic        pwr_dn_req_i;
  logic [63:0] boot_addr_i;
  logic        byp_i;
  logic        cluster_busy_i;
  logic        cluster_pow_o;
  logic        cluster_byp_o;
  logic        cluster_clk_en_o;
  logic        cluster_rstn_o;
  logic        cluster_fetch_enable_o;
  logic [63:0] cluster_boot_addr_o;
  logic        done_o;
  logic        req_err_o;
  logic        timeout_o;
  logic [2:0]  state_o;

  modport slave (
    input  pwr_up_req_i, pwr_dn_req_i, boot_addr_i, byp_i, cluster_busy_i,
    output cluster_pow_o, cluster_byp_o, cluster_clk_en_o, cluster_rstn_o,
           cluster_fetch_enable_o, cluster_boot_addr_o, done_o, req_err_o,
           timeout_o, state_o
  );

  modport master (
    output pwr_up_req_i, pwr_dn_req_i, boot_addr_i, byp_i, cluster_busy_i,
    input  cluster_pow_o, cluster_byp_o, cluster_clk_en_o, cluster_rstn_o,
           cluster_fetch_enable_o, cluster_boot_addr_o, done_o, req_err_o,
           timeout_o, state_o
  );
endinterface

// File: rtl/cluster_pwr_seq.sv
// Timed power-up / drain-and-power-down sequencer for the cluster control lines.
//
// state      | meaning
// OFF        | cluster unpowered, waiting for power-up request
// PWR_ON     | power applied, waiting for rail to settle
// CLK_EN     | clock running, reset still held
// RST_REL    | reset released, waiting before fetch
// RUN        | fetch enabled, cluster running
// DRAIN      | waiting for busy low two cycles (or timeout)
// RST_ASSERT | reset re-asserted with clock still running
// CLK_OFF    | clock gated, power held before turn-off
module cluster_pwr_seq #(
  parameter int PWR_ON_CYCLES = 16,
  parameter int CLK_CYCLES    = 4,
  parameter int RST_CYCLES    = 8,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = $clog2(
    ((PWR_ON_CYCLES > CLK_CYCLES ? PWR_ON_CYCLES : CLK_CYCLES) >
     (RST_CYCLES > DRAIN_TIMEOUT ? RST_CYCLES : DRAIN_TIMEOUT)) ?
    (PWR_ON_CYCLES > CLK_CYCLES ? PWR_ON_CYCLES : CLK_CYCLES) :
    (RST_CYCLES > DRAIN_TIMEOUT ? RST_CYCLES : DRAIN_TIMEOUT)) + 1
) (
  input logic               clk_i,
  input logic               rst_ni,
  cluster_pwr_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    PWR_ON     = 3'd1,
    CLK_EN     = 3'd2,
    RST_REL    = 3'd3,
    RUN        = 3'd4,
    DRAIN      = 3'd5,
    RST_ASSERT = 3'd6,
    CLK_OFF    = 3'd7
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  low_q, low_d;
  logic                  tmo_q, tmo_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  latch_cfg;
  logic [63:0]           boot_q;
  logic                  byp_q;
  logic                  pow_q, clk_en_q, rstn_q, fetch_q;
  logic                  up, dn, cnt_zero;

  assign up       = bus.pwr_up_req_i;
  assign dn       = bus.pwr_dn_req_i;
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_zero ? cnt_q : cnt_q - CNT_WIDTH'(1);
    low_d     = low_q;
    tmo_d     = tmo_q;
    done_d    = 1'b0;
    latch_cfg = 1'b0;
    // Only the request matching the current accepting state is honoured.
    if (state_q == OFF)      err_d = dn && !up;
    else if (state_q == RUN) err_d = up && !dn;
    else                     err_d = up || dn;

    case (state_q)
      OFF: begin
        if (up) begin
          latch_cfg = 1'b1;
          tmo_d     = 1'b0;
          cnt_d     = CNT_WIDTH'(PWR_ON_CYCLES - 1);
          state_d   = PWR_ON;
        end
      end
      PWR_ON: begin
        if (cnt_zero) begin
          cnt_d   = CNT_WIDTH'(CLK_CYCLES - 1);
          state_d = CLK_EN;
        end
      end
      CLK_EN: begin
        if (cnt_zero) begin
          cnt_d   = CNT_WIDTH'(RST_CYCLES - 1);
          state_d = RST_REL;
        end
      end
      RST_REL: begin
        if (cnt_zero) begin
          done_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (dn) begin
          cnt_d   = CNT_WIDTH'(DRAIN_TIMEOUT - 1);
          low_d   = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // A completed idle qualification wins over a timeout in the same cycle.
        low_d = !bus.cluster_busy_i;
        if (!bus.cluster_busy_i && low_q) begin
          cnt_d   = CNT_WIDTH'(RST_CYCLES - 1);
          state_d = RST_ASSERT;
        end else if (cnt_zero) begin
          tmo_d   = 1'b1;
          cnt_d   = CNT_WIDTH'(RST_CYCLES - 1);
          state_d = RST_ASSERT;
        end
      end
      RST_ASSERT: begin
        if (cnt_zero) begin
          cnt_d   = CNT_WIDTH'(CLK_CYCLES - 1);
          state_d = CLK_OFF;
        end
      end
      CLK_OFF: begin
        if (cnt_zero) begin
          done_d  = 1'b1;
          state_d = OFF;
        end
      end
      default: state_d = OFF;
    endcase
  end

  // Output lines are decoded from the next state so they change with the state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      low_q    <= 1'b0;
      tmo_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      boot_q   <= '0;
      byp_q    <= 1'b0;
      pow_q    <= 1'b0;
      clk_en_q <= 1'b0;
      rstn_q   <= 1'b0;
      fetch_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      low_q    <= low_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
      err_q    <= err_d;
      if (latch_cfg) begin
        boot_q <= bus.boot_addr_i;
        byp_q  <= bus.byp_i;
      end
      pow_q    <= (state_d != OFF);
      clk_en_q <= (state_d == CLK_EN) || (state_d == RST_REL) || (state_d == RUN) ||
                  (state_d == DRAIN) || (state_d == RST_ASSERT);
      rstn_q   <= (state_d == RST_REL) || (state_d == RUN) || (state_d == DRAIN);
      fetch_q  <= (state_d == RUN);
    end
  end

  assign bus.cluster_pow_o          = pow_q;
  assign bus.cluster_byp_o          = byp_q;
  assign bus.cluster_clk_en_o       = clk_en_q;
  assign bus.cluster_rstn_o         = rstn_q;
  assign bus.cluster_fetch_enable_o = fetch_q;
  assign bus.cluster_boot_addr_o    = boot_q;
  assign bus.done_o                 = done_q;
  assign bus.req_err_o              = err_q;
  assign bus.timeout_o              = tmo_q;
  assign bus.state_o                = state_q;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Scoreboard bench for cluster_pwr_seq: stimulus queues timed expectations,
// a negedge monitor compares levels and done/req_err pulses against them.
module tb_cluster_pwr_seq;
  localparam int S_STATE = 0, S_POW = 1, S_CLK = 2, S_RSTN = 3, S_FETCH = 4,
                 S_TMO = 5, S_BOOT = 6, S_BYP = 7;
  localparam logic [63:0] BOOT_A = 64'h0000_0000_1C00_8080;
  localparam logic [63:0] BOOT_B = 64'h8000_0000_0000_0100;
  localparam logic [63:0] BOOT_C = 64'h0000_0001_2345_6780;

  typedef struct {
    int          cyc;
    int          sig;
    logic [63:0] val;
  } chk_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  chk_t chk_q[$];
  int   done_q[$];
  int   err_q[$];
  chk_t mon_e;
  int   c;

  cluster_pwr_seq_if bus();

  cluster_pwr_seq #(.DRAIN_TIMEOUT(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] sample(int s);
    case (s)
      S_STATE: return {61'd0, bus.state_o};
      S_POW:   return {63'd0, bus.cluster_pow_o};
      S_CLK:   return {63'd0, bus.cluster_clk_en_o};
      S_RSTN:  return {63'd0, bus.cluster_rstn_o};
      S_FETCH: return {63'd0, bus.cluster_fetch_enable_o};
      S_TMO:   return {63'd0, bus.timeout_o};
      S_BOOT:  return bus.cluster_boot_addr_o;
      default: return {63'd0, bus.cluster_byp_o};
    endcase
  endfunction

  function automatic string sig_name(int s);
    case (s)
      S_STATE: return "state";
      S_POW:   return "pow";
      S_CLK:   return "clk_en";
      S_RSTN:  return "rstn";
      S_FETCH: return "fetch";
      S_TMO:   return "timeout";
      S_BOOT:  return "boot_addr";
      default: return "byp";
    endcase
  endfunction

  task automatic expect_at(int at, int s, logic [63:0] v);
    chk_t e;
    e.cyc = at; e.sig = s; e.val = v;
    chk_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int target);
    while (cyc < target) tick();
  endtask

  task automatic req(logic u, logic d);
    bus.pwr_up_req_i = u;
    bus.pwr_dn_req_i = d;
    tick();
    bus.pwr_up_req_i = 1'b0;
    bus.pwr_dn_req_i = 1'b0;
  endtask

  // Monitor: level checks due this cycle, then any pulse the DUT presents.
  always @(negedge clk) begin
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      mon_e = chk_q.pop_front();
      total++;
      if (mon_e.cyc == cyc && sample(mon_e.sig) == mon_e.val) passed++;
      else $display("FAIL %s at cycle %0d: got %0h expected %0h (checked at %0d)",
                    sig_name(mon_e.sig), mon_e.cyc, sample(mon_e.sig), mon_e.val, cyc);
    end
    while (done_q.size() > 0 && done_q[0] < cyc) begin
      total++;
      $display("FAIL done_missing: expected pulse at cycle %0d, got none", done_q.pop_front());
    end
    while (err_q.size() > 0 && err_q[0] < cyc) begin
      total++;
      $display("FAIL req_err_missing: expected pulse at cycle %0d, got none", err_q.pop_front());
    end
    if (bus.done_o) begin
      total++;
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        void'(done_q.pop_front());
        passed++;
      end else $display("FAIL done_unexpected: got pulse at cycle %0d, expected none", cyc);
    end
    if (bus.req_err_o) begin
      total++;
      if (err_q.size() > 0 && err_q[0] == cyc) begin
        void'(err_q.pop_front());
        passed++;
      end else $display("FAIL req_err_unexpected: got pulse at cycle %0d, expected none", cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.pwr_up_req_i   = 1'b0;
    bus.pwr_dn_req_i   = 1'b0;
    bus.boot_addr_i    = '0;
    bus.byp_i          = 1'b0;
    bus.cluster_busy_i = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    c = cyc;
    expect_at(c, S_STATE, 0); expect_at(c, S_POW, 0); expect_at(c, S_CLK, 0);
    expect_at(c, S_RSTN, 0);  expect_at(c, S_FETCH, 0); expect_at(c, S_TMO, 0);
    expect_at(c, S_BOOT, 0);  expect_at(c, S_BYP, 0);
    tick();

    // down request while OFF is rejected
    c = cyc;
    err_q.push_back(c + 1);
    expect_at(c + 1, S_STATE, 0);
    expect_at(c + 1, S_POW, 0);
    req(1'b0, 1'b1);
    wait_cyc(c + 3);

    // full power-up with defaults; stray up request during CLK_EN
    c = cyc;
    bus.boot_addr_i = BOOT_A;
    bus.byp_i = 1'b1;
    expect_at(c + 1, S_POW, 1);    expect_at(c + 1, S_STATE, 1);
    expect_at(c + 16, S_CLK, 0);   expect_at(c + 17, S_CLK, 1);
    expect_at(c + 17, S_STATE, 2); expect_at(c + 19, S_STATE, 2);
    expect_at(c + 20, S_RSTN, 0);  expect_at(c + 21, S_RSTN, 1);
    expect_at(c + 21, S_STATE, 3); expect_at(c + 28, S_FETCH, 0);
    expect_at(c + 29, S_FETCH, 1); expect_at(c + 29, S_STATE, 4);
    expect_at(c + 29, S_BOOT, BOOT_A); expect_at(c + 29, S_BYP, 1);
    err_q.push_back(c + 19);
    done_q.push_back(c + 29);
    req(1'b1, 1'b0);
    bus.boot_addr_i = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.byp_i = 1'b0;
    wait_cyc(c + 18);
    req(1'b1, 1'b0);
    wait_cyc(c + 32);

    // power-down with busy low
    c = cyc;
    expect_at(c + 1, S_FETCH, 0);  expect_at(c + 1, S_STATE, 5);
    expect_at(c + 1, S_RSTN, 1);   expect_at(c + 3, S_STATE, 6);
    expect_at(c + 3, S_RSTN, 0);   expect_at(c + 3, S_CLK, 1);
    expect_at(c + 10, S_CLK, 1);   expect_at(c + 11, S_CLK, 0);
    expect_at(c + 11, S_STATE, 7); expect_at(c + 14, S_POW, 1);
    expect_at(c + 15, S_POW, 0);   expect_at(c + 15, S_STATE, 0);
    expect_at(c + 15, S_BOOT, BOOT_A); expect_at(c + 15, S_TMO, 0);
    done_q.push_back(c + 15);
    req(1'b0, 1'b1);
    wait_cyc(c + 17);

    // simultaneous up+down in OFF: power-up, no error
    c = cyc;
    bus.boot_addr_i = BOOT_B;
    bus.byp_i = 1'b0;
    expect_at(c + 1, S_POW, 1);    expect_at(c + 1, S_STATE, 1);
    expect_at(c + 29, S_STATE, 4); expect_at(c + 29, S_BOOT, BOOT_B);
    expect_at(c + 29, S_BYP, 0);
    done_q.push_back(c + 29);
    req(1'b1, 1'b1);
    wait_cyc(c + 31);

    // simultaneous up+down in RUN with busy stuck high: drain times out
    c = cyc;
    bus.cluster_busy_i = 1'b1;
    expect_at(c + 1, S_STATE, 5);  expect_at(c + 1, S_FETCH, 0);
    expect_at(c + 16, S_STATE, 5); expect_at(c + 16, S_TMO, 0);
    expect_at(c + 17, S_STATE, 6); expect_at(c + 17, S_TMO, 1);
    expect_at(c + 17, S_RSTN, 0);  expect_at(c + 24, S_CLK, 1);
    expect_at(c + 25, S_CLK, 0);   expect_at(c + 29, S_STATE, 0);
    expect_at(c + 29, S_POW, 0);   expect_at(c + 29, S_TMO, 1);
    done_q.push_back(c + 29);
    req(1'b1, 1'b1);
    wait_cyc(c + 20);
    bus.cluster_busy_i = 1'b0;
    wait_cyc(c + 31);

    // next power-up clears timeout; reset during RST_REL forces everything off
    c = cyc;
    bus.boot_addr_i = BOOT_A;
    bus.byp_i = 1'b1;
    expect_at(c + 1, S_TMO, 0);    expect_at(c + 1, S_STATE, 1);
    expect_at(c + 21, S_STATE, 3); expect_at(c + 21, S_RSTN, 1);
    expect_at(c + 24, S_STATE, 0); expect_at(c + 24, S_POW, 0);
    expect_at(c + 24, S_CLK, 0);   expect_at(c + 24, S_RSTN, 0);
    expect_at(c + 24, S_BOOT, 0);  expect_at(c + 24, S_BYP, 0);
    expect_at(c + 24, S_TMO, 0);
    req(1'b1, 1'b0);
    wait_cyc(c + 23);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_cyc(c + 26);

    // full sequence after reset, then drain with a one-cycle busy glitch
    c = cyc;
    bus.boot_addr_i = BOOT_C;
    expect_at(c + 1, S_POW, 1);    expect_at(c + 17, S_CLK, 1);
    expect_at(c + 21, S_RSTN, 1);  expect_at(c + 29, S_FETCH, 1);
    expect_at(c + 29, S_BOOT, BOOT_C);
    done_q.push_back(c + 29);
    req(1'b1, 1'b0);
    wait_cyc(c + 31);

    c = cyc;
    expect_at(c + 1, S_STATE, 5);  expect_at(c + 3, S_STATE, 5);
    expect_at(c + 4, S_STATE, 6);  expect_at(c + 4, S_TMO, 0);
    expect_at(c + 16, S_STATE, 0);
    done_q.push_back(c + 16);
    req(1'b0, 1'b1);
    bus.cluster_busy_i = 1'b1;
    tick();
    bus.cluster_busy_i = 1'b0;
    wait_cyc(c + 19);

    tick();
    while (chk_q.size() > 0) begin
      mon_e = chk_q.pop_front();
      total++;
      $display("FAIL %s_unchecked: expected %0h at cycle %0d, never reached", sig_name(mon_e.sig), mon_e.val, mon_e.cyc);
    end
    while (done_q.size() > 0) begin
      total++;
      $display("FAIL done_missing: expected pulse at cycle %0d, got none", done_q.pop_front());
    end
    while (err_q.size() > 0) begin
      total++;
      $display("FAIL req_err_missing: expected pulse at cycle %0d, got none", err_q.pop_front());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
